// File: rtl/relm_push_arbiter_pkg.sv
// Shared types and helpers for the ReLM push arbiter.
// Lock state enum, index width and round-robin position math.
package relm_push_arbiter_pkg;

    typedef enum logic {
        LK_FREE = 1'b0,
        LK_HELD = 1'b1
    } lock_e;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Requester examined at priority step k (1 = highest) after the last winner.
    function automatic int rr_pos(input int last, input int k, input int n);
        return (last + k) % n;
    endfunction

endpackage

// File: rtl/relm_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping.
// Produces one-hot and binary forms of the winner plus an any-request flag.
module relm_rr_pick
    import relm_push_arbiter_pkg::*;
#(
    parameter int N = 3,
    localparam int WG = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [WG-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [WG-1:0] idx,
    output logic          any
);

    // Walk from lowest to highest priority so the best match is written last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if (i == rr_pos(int'(last), k, N) && req[i]) begin
                    onehot    = '0;
                    onehot[i] = 1'b1;
                    idx       = WG'(i);
                    any       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/relm_push_arbiter.sv
// Shares one ReLM push sink among NREQ requesters: round-robin with optional
// packet lock, one output holding register and retry back-pressure.
module relm_push_arbiter
    import relm_push_arbiter_pkg::*;
#(
    parameter int WD      = 32,
    parameter int NREQ    = 3,
    parameter int LOCK_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ*(WD+1)-1:0]   req_d,
    output logic [NREQ-1:0]          req_retry,
    output logic [WD:0]              out_d,
    input  logic                     out_retry,
    output logic [NREQ-1:0]          grant_out
);

    localparam int WG       = idx_w(NREQ);
    localparam int LOCK_BIT = WD - 1;

    logic [NREQ-1:0]          stb;
    logic [NREQ-1:0][WD-1:0]  pay;
    logic [NREQ-1:0]          owner_oh;
    logic [NREQ-1:0]          cand;
    logic [NREQ-1:0]          pick_oh;
    logic [NREQ-1:0]          acc_oh;
    logic [WG-1:0]            pick_idx;
    logic                     pick_any;
    logic [WG-1:0]            last;
    logic [WG-1:0]            owner;
    lock_e                    lock_q;
    lock_e                    lock_nxt;
    logic                     hold_v;
    logic                     adv;
    logic                     acc;
    logic [WD-1:0]            sel;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign stb[i]      = req_d[(WD+1)*i + WD];
        assign pay[i]      = req_d[(WD+1)*i +: WD];
        assign owner_oh[i] = (owner == WG'(i));
    end

    assign hold_v = out_d[WD];
    // The register can take a word when empty or when the sink drains it this cycle.
    assign adv    = !hold_v || !out_retry;

    // While locked only the owner is a candidate; others keep retrying.
    assign cand = (lock_q == LK_HELD) ? (stb & owner_oh) : stb;

    relm_rr_pick #(.N(NREQ)) u_pick (
        .req    (cand),
        .last   (last),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign acc       = adv && pick_any;
    assign acc_oh    = {NREQ{acc}} & pick_oh;
    assign req_retry = stb & ~acc_oh;
    assign grant_out = (lock_q == LK_HELD) ? owner_oh : '0;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) sel = sel | pay[i];
        end
    end

    always_comb begin
        lock_nxt = lock_q;
        if (acc) lock_nxt = ((LOCK_EN != 0) && sel[LOCK_BIT]) ? LK_HELD : LK_FREE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_d  <= '0;
            last   <= WG'(NREQ - 1);
            owner  <= '0;
            lock_q <= LK_FREE;
        end else begin
            lock_q <= lock_nxt;
            if (acc) begin
                out_d <= {1'b1, sel};
                last  <= pick_idx;
                owner <= pick_idx;
            end else if (adv) begin
                out_d[WD] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_relm_push_arbiter.sv
// Scoreboard bench for relm_push_arbiter (WD=32, NREQ=3, LOCK_EN=1): a small
// arbitration model predicts accepts/retries and queues expected output words.
module tb_relm_push_arbiter;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        st;
    logic [31:0]       pl [3];
    logic              out_retry;
    logic [3*33-1:0]   req_d;
    logic [2:0]        req_retry;
    logic [32:0]       out_d;
    logic [2:0]        grant_out;

    int checks = 0;
    int failures = 0;

    int          m_last;
    bit          m_locked;
    int          m_owner;
    bit          m_hold;
    bit          m_new;
    logic [31:0] q [$];

    always #5 clk = ~clk;

    always_comb begin
        req_d = '0;
        for (int i = 0; i < 3; i++) req_d[33*i +: 33] = {st[i], pl[i]};
    end

    relm_push_arbiter #(.WD(32), .NREQ(3), .LOCK_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_d     (req_d),
        .req_retry (req_retry),
        .out_d     (out_d),
        .out_retry (out_retry),
        .grant_out (grant_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: check at the negedge, advance the model at the posedge, return at posedge+1.
    task automatic step();
        bit          adv;
        bit          acc;
        int          pick;
        logic [2:0]  er;
        logic [2:0]  eg;
        #4;
        chk("hold", out_d[32], m_hold);
        if (m_new) begin
            if (q.size() == 0) chk("sb_underflow", 64'(q.size()), 64'd1);
            else               chk("sb_data", out_d[31:0], q.pop_front());
        end
        adv  = !m_hold || !out_retry;
        acc  = 1'b0;
        pick = 0;
        if (adv) begin
            if (m_locked) begin
                if (st[m_owner]) begin acc = 1'b1; pick = m_owner; end
            end else begin
                for (int k = 1; k <= 3; k++) begin
                    if (!acc && st[(m_last + k) % 3]) begin acc = 1'b1; pick = (m_last + k) % 3; end
                end
            end
        end
        er = st;
        if (acc) er[pick] = 1'b0;
        eg = m_locked ? 3'(1 << m_owner) : 3'b000;
        chk("req_retry", req_retry, er);
        chk("grant", grant_out, eg);
        @(posedge clk);
        if (acc) begin
            q.push_back(pl[pick]);
            m_last   = pick;
            m_locked = pl[pick][31];
            m_owner  = pick;
            m_hold   = 1'b1;
            m_new    = 1'b1;
        end else begin
            if (adv) m_hold = 1'b0;
            m_new = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_d", out_d, 33'd0);
        chk("rst_grant", grant_out, 3'b000);
        st = '0;
        m_last = 2; m_locked = 1'b0; m_owner = 0; m_hold = 1'b0; m_new = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        st = '0; out_retry = 1'b0;
        for (int i = 0; i < 3; i++) pl[i] = '0;
        do_reset();
        chk("rst_retry", req_retry, 3'b000);

        // 1: single word from req0
        pl[0] = 32'h11; st = 3'b001;
        step();
        chk("t1_out", out_d, {1'b1, 32'h11});
        st = 3'b000;
        step();
        chk("t1_empty", out_d[32], 1'b0);
        step();

        // 2: three requesters, per-word round robin
        do_reset();
        pl[0] = 32'h20; pl[1] = 32'h21; pl[2] = 32'h22; st = 3'b111;
        for (int n = 0; n < 6; n++) begin
            step();
            chk("t2_order", out_d[31:0], 32'h20 + 32'(n % 3));
        end
        st = 3'b000;
        step();

        // 3: locked two-word packet from req1
        do_reset();
        pl[0] = 32'h30; st = 3'b001;
        step();
        pl[1] = 32'h8000_0001; pl[2] = 32'h32; st = 3'b111;
        step();
        chk("t3_lockword", out_d[31:0], 32'h8000_0001);
        chk("t3_grant", grant_out, 3'b010);
        pl[1] = 32'h02;
        step();
        chk("t3_second", out_d[31:0], 32'h02);
        chk("t3_unlock", grant_out, 3'b000);
        st = 3'b101;
        step();
        chk("t3_next_req2", out_d[31:0], 32'h32);
        st = 3'b000;
        step();

        // 4: back-pressure holds the register
        do_reset();
        pl[0] = 32'hAA; st = 3'b001;
        step();
        pl[0] = 32'hBB; out_retry = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("t4_hold", out_d, {1'b1, 32'hAA});
            chk("t4_retry0", req_retry[0], 1'b1);
        end
        out_retry = 1'b0;
        step();
        chk("t4_refill", out_d, {1'b1, 32'hBB});
        st = 3'b000;
        step();

        // 5: asynchronous reset while holding a locked word
        do_reset();
        pl[1] = 32'h8000_0005; st = 3'b010;
        step();
        chk("t5_locked", grant_out, 3'b010);
        #2;
        do_reset();
        pl[0] = 32'h50; pl[1] = 32'h51; pl[2] = 32'h52; st = 3'b111;
        step();
        chk("t5_first_req0", out_d[31:0], 32'h50);
        st = 3'b000;
        step();

        // 6: lock owner stalls, req2 waits
        do_reset();
        pl[0] = 32'h8000_0010; pl[2] = 32'h60; st = 3'b101;
        step();
        chk("t6_lock", grant_out, 3'b001);
        st = 3'b100;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("t6_noout", out_d[32], 1'b0);
            chk("t6_retry", req_retry, 3'b100);
        end
        pl[0] = 32'h11; st = 3'b101;
        step();
        chk("t6_final", out_d, {1'b1, 32'h11});
        chk("t6_release", grant_out, 3'b000);
        st = 3'b100;
        step();
        chk("t6_req2", out_d[31:0], 32'h60);
        st = 3'b000;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
